// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipelined_barrel_shifter                                   |
// | Description : Pipelined barrel shifter (SLL/SRL/SRA/ROR/ROL). There is   |
// |               one register stage per shift-amount bit, linked by a       |
// |               valid/ready handshake with backpressure and flush.         |
// |               Define SHIFTER_CARRY_EN to add the out_carry output.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef SHIFTER_CARRY_EN
  output logic             out_carry,
`endif
  output logic             out_op_err
);

  localparam logic [2:0] c_OP_SLL = 3'b001;
  localparam logic [2:0] c_OP_SRL = 3'b010;
  localparam logic [2:0] c_OP_SRA = 3'b100;
  localparam logic [2:0] c_OP_ROR = 3'b110;
  localparam logic [2:0] c_OP_ROL = 3'b111;

  logic w_op_err;

  // Classify the op once at entry; the error flag then rides the pipeline.
  always_comb begin
    w_op_err = 1'b1;
    case (in_op)
      c_OP_SLL, c_OP_SRL, c_OP_SRA, c_OP_ROR, c_OP_ROL: w_op_err = 1'b0;
      default:                                          w_op_err = 1'b1;
    endcase
  end

  // Stage k applies a shift of 2^k when bit k of the amount is set. The
  // amount register shrinks by one bit per stage because each stage consumes
  // the LSB of what is left.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int c_SH = 1 << k;
    localparam int c_AW = SHW - k;

    logic             w_in_vld;
    logic [WIDTH-1:0] w_in_data;
    logic [2:0]       w_in_op;
    logic [c_AW-1:0]  w_in_amt;
    logic             w_in_sign;
    logic             w_in_err;
    logic [WIDTH-1:0] w_sh_data;
    logic             w_load;
    logic             r_vld;
    logic [WIDTH-1:0] r_data;
    logic             r_err;
`ifdef SHIFTER_CARRY_EN
    logic             w_in_carry;
    logic             w_sh_carry;
    logic             r_carry;
`endif

    if (k == 0) begin : g_src_in
      assign w_in_vld   = in_valid;
      assign w_in_data  = in_data;
      assign w_in_op    = in_op;
      assign w_in_amt   = in_amt;
      assign w_in_sign  = in_data[WIDTH-1];
      assign w_in_err   = w_op_err;
`ifdef SHIFTER_CARRY_EN
      assign w_in_carry = 1'b0;
`endif
    end else begin : g_src_prev
      assign w_in_vld   = g_stage[k-1].r_vld;
      assign w_in_data  = g_stage[k-1].r_data;
      assign w_in_op    = g_stage[k-1].g_fwd.r_op;
      assign w_in_amt   = g_stage[k-1].g_fwd.r_amt;
      assign w_in_sign  = g_stage[k-1].g_fwd.r_sign;
      assign w_in_err   = g_stage[k-1].r_err;
`ifdef SHIFTER_CARRY_EN
      assign w_in_carry = g_stage[k-1].r_carry;
`endif
    end

    // A stage may load when it is empty or when its own contents move on.
    if (k == SHW - 1) begin : g_load_last
      assign w_load = !r_vld || out_ready;
    end else begin : g_load_chain
      assign w_load = !r_vld || g_stage[k+1].w_load;
    end

    // Fixed-distance shift/rotate for this stage; illegal ops pass through.
    always_comb begin
      w_sh_data = w_in_data;
`ifdef SHIFTER_CARRY_EN
      w_sh_carry = w_in_carry;
`endif
      if (w_in_amt[0] && !w_in_err) begin
        case (w_in_op)
          c_OP_SLL: begin
            w_sh_data = {w_in_data[WIDTH-c_SH-1:0], {c_SH{1'b0}}};
`ifdef SHIFTER_CARRY_EN
            w_sh_carry = w_in_data[WIDTH-c_SH];
`endif
          end
          c_OP_SRL: begin
            w_sh_data = {{c_SH{1'b0}}, w_in_data[WIDTH-1:c_SH]};
`ifdef SHIFTER_CARRY_EN
            w_sh_carry = w_in_data[c_SH-1];
`endif
          end
          c_OP_SRA: begin
            w_sh_data = {{c_SH{w_in_sign}}, w_in_data[WIDTH-1:c_SH]};
`ifdef SHIFTER_CARRY_EN
            w_sh_carry = w_in_data[c_SH-1];
`endif
          end
          c_OP_ROR: begin
            w_sh_data = {w_in_data[c_SH-1:0], w_in_data[WIDTH-1:c_SH]};
`ifdef SHIFTER_CARRY_EN
            w_sh_carry = w_in_data[c_SH-1];
`endif
          end
          c_OP_ROL: begin
            w_sh_data = {w_in_data[WIDTH-c_SH-1:0], w_in_data[WIDTH-1:WIDTH-c_SH]};
`ifdef SHIFTER_CARRY_EN
            w_sh_carry = w_in_data[WIDTH-c_SH];
`endif
          end
          default: ;
        endcase
      end
    end

    // Stage register: flush beats load; data only moves with a valid op.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld  <= 1'b0;
        r_data <= '0;
        r_err  <= 1'b0;
      end else if (flush) begin
        r_vld  <= 1'b0;
      end else if (w_load) begin
        r_vld <= w_in_vld;
        if (w_in_vld) begin
          r_data <= w_sh_data;
          r_err  <= w_in_err;
        end
      end
    end

`ifdef SHIFTER_CARRY_EN
    // Carry travels with the data it describes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_carry <= 1'b0;
      end else if (!flush && w_load && w_in_vld) begin
        r_carry <= w_sh_carry;
      end
    end
`endif

    // Control fields are only needed by later stages, so the last stage has none.
    if (k < SHW - 1) begin : g_fwd
      logic [2:0]      r_op;
      logic            r_sign;
      logic [c_AW-2:0] r_amt;

      // Forward op, original sign and the not-yet-consumed amount bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_op   <= 3'b000;
          r_sign <= 1'b0;
          r_amt  <= '0;
        end else if (!flush && w_load && w_in_vld) begin
          r_op   <= w_in_op;
          r_sign <= w_in_sign;
          r_amt  <= w_in_amt[c_AW-1:1];
        end
      end
    end
  end

  assign in_ready   = g_stage[0].w_load;
  assign out_valid  = g_stage[SHW-1].r_vld;
  assign out_data   = g_stage[SHW-1].r_data;
  assign out_op_err = g_stage[SHW-1].r_err;
`ifdef SHIFTER_CARRY_EN
  assign out_carry  = g_stage[SHW-1].r_carry;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipelined_barrel_shifter                                |
// | Description : Self-checking bench for pipelined_barrel_shifter (WIDTH=32)|
// |               Also covers out_carry when SHIFTER_CARRY_EN is defined.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pipelined_barrel_shifter;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [SHW-1:0]   in_amt = '0;
  logic [2:0]       in_op = 3'b000;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_op_err;
`ifdef SHIFTER_CARRY_EN
  logic             out_carry;
`endif

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef SHIFTER_CARRY_EN
    .out_carry  (out_carry),
`endif
    .out_op_err (out_op_err)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    logic        c;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b0;
  bit          held = 1'b0;
  logic [31:0] held_d;
  logic        held_e;
  logic [31:0] sd[20];
  logic [4:0]  sa[20];
  logic [2:0]  so[20];
  logic [2:0]  legal_ops[5] = '{3'b001, 3'b010, 3'b100, 3'b110, 3'b111};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [31:0] d, input int a, input logic [2:0] op);
    logic signed [31:0] s;
    s = d;
    case (op)
      3'b001:  return d << a;
      3'b010:  return d >> a;
      3'b100:  return s >>> a;
      3'b110:  return (a == 0) ? d : ((d >> a) | (d << (32 - a)));
      3'b111:  return (a == 0) ? d : ((d << a) | (d >> (32 - a)));
      default: return d;
    endcase
  endfunction

  function automatic logic ref_carry(input logic [31:0] d, input int a, input logic [2:0] op);
    logic [31:0] r;
    r = ref_res(d, a, op);
    if (a == 0) return 1'b0;
    case (op)
      3'b001:         return d[32-a];
      3'b010, 3'b100: return d[a-1];
      3'b110:         return r[31];
      3'b111:         return r[0];
      default:        return 1'b0;
    endcase
  endfunction

  // One clock cycle: drive inputs just after the edge, sample, then step.
  task automatic drive_cycle(input logic v, input logic [31:0] d, input logic [4:0] a,
                             input logic [2:0] op, input logic ordy, input logic fl,
                             input logic [31:0] ed, input logic ee, input logic ec,
                             output logic acc);
    in_valid  = v;
    in_data   = d;
    in_amt    = a;
    in_op     = op;
    out_ready = ordy;
    flush     = fl;
    #1;
    acc = v && in_ready && !fl;
    if (held) begin
      check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stall_data", out_data, held_d);
      check_eq("stall_err", {31'd0, out_op_err}, {31'd0, held_e});
    end
    if (out_valid && out_ready && !fl) begin
      if (q.size() == 0) begin
        check_eq("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_eq("data", out_data, e.d);
        check_eq("op_err", {31'd0, out_op_err}, {31'd0, e.e});
`ifdef SHIFTER_CARRY_EN
        check_eq("carry", {31'd0, out_carry}, {31'd0, e.c});
`endif
        if (chk_lat) check_eq("latency", cyc - e.cyc, SHW);
      end
    end
    held   = out_valid && !out_ready && !fl;
    held_d = out_data;
    held_e = out_op_err;
    if (acc) q.push_back('{d: ed, e: ee, c: ec, cyc: cyc});
    if (fl) q.delete();
    @(posedge clk);
    #1;
    cyc++;
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, 3'b000, ordy, 1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (q.size() > 0 && b > 0) begin
      idle(1, 1'b1);
      b--;
    end
    if (q.size() != 0) check_eq("drain_timeout", q.size(), 0);
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [2:0] op,
                      input logic [31:0] ed, input logic ee, input logic ec);
    logic acc;
    drive_cycle(1'b1, d, a, op, 1'b1, 1'b0, ed, ee, ec, acc);
    if (!acc) check_eq("send_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic run_stream(input bit bp);
    int i;
    int k;
    logic acc;
    logic ordy;
    i = 0;
    k = 0;
    while (i < 20 && k < 300) begin
      ordy = bp ? ((k < 8) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
      drive_cycle(1'b1, sd[i], sa[i], so[i], ordy, 1'b0,
                  ref_res(sd[i], int'(sa[i]), so[i]), 1'b0, ref_carry(sd[i], int'(sa[i]), so[i]), acc);
      if (bp && k == 4) check_eq("bp_ready_fill", {31'd0, acc}, 32'd1);
      if (bp && k == 5) check_eq("bp_ready_full", {31'd0, acc}, 32'd0);
      if (bp && k == 7) check_eq("bp_ready_stall", {31'd0, acc}, 32'd0);
      if (acc) i++;
      k++;
    end
    if (i < 20) check_eq("stream_timeout", i, 20);
    drain(300);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic acc;
    for (int i = 0; i < 20; i++) begin
      sd[i] = $urandom;
      sa[i] = 5'($urandom_range(0, 31));
      so[i] = legal_ops[$urandom_range(0, 4)];
    end
    sa[5]  = 5'd0;
    sd[10] = 32'h8000_0000;
    sa[10] = 5'd31;
    so[10] = 3'b100;
    sd[11] = 32'hFFFF_FFFF;
    sa[11] = 5'd31;
    so[11] = 3'b010;

    // Reset state
    #3;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_err", {31'd0, out_op_err}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single ops on 0x8000_00F1, A=4, with latency checked
    chk_lat = 1'b1;
    send(32'h8000_00F1, 5'd4, 3'b001, 32'h0000_0F10, 1'b0, 1'b0); drain(20);
    send(32'h8000_00F1, 5'd4, 3'b010, 32'h0800_000F, 1'b0, 1'b0); drain(20);
    send(32'h8000_00F1, 5'd4, 3'b100, 32'hF800_000F, 1'b0, 1'b0); drain(20);
    send(32'h8000_00F1, 5'd4, 3'b110, 32'h1800_000F, 1'b0, 1'b0); drain(20);
    send(32'h8000_00F1, 5'd4, 3'b111, 32'h0000_0F18, 1'b0, 1'b0); drain(20);

    // Illegal op followed by a legal one, back to back
    send(32'h1234_5678, 5'd4, 3'b011, 32'h1234_5678, 1'b1, 1'b0);
    send(32'h1234_5678, 5'd0, 3'b001, 32'h1234_5678, 1'b0, 1'b0);
    drain(20);

    // Carry vectors and boundary amounts
    send(32'h0000_0008, 5'd4, 3'b010, 32'h0000_0000, 1'b0, 1'b1);
    send(32'h8000_0000, 5'd1, 3'b001, 32'h0000_0000, 1'b0, 1'b1);
    send(32'h0000_0001, 5'd0, 3'b110, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h8000_0000, 5'd31, 3'b100, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'h0000_0001, 5'd31, 3'b110, 32'h0000_0002, 1'b0, 1'b0);
    drain(20);

    // Back-to-back stream, then the same stream under backpressure
    run_stream(1'b0);
    chk_lat = 1'b0;
    run_stream(1'b1);

    // Flush with three ops in flight and a new input in the same cycle
    send(32'h0000_0001, 5'd1, 3'b001, 32'h0000_0002, 1'b0, 1'b0);
    send(32'h0000_0002, 5'd1, 3'b001, 32'h0000_0004, 1'b0, 1'b0);
    send(32'h0000_0003, 5'd1, 3'b001, 32'h0000_0006, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h0000_0004, 5'd1, 3'b001, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b0, acc);
    check_eq("flush_out_valid", {31'd0, out_valid}, 32'd0);
    idle(12, 1'b1);
    send(32'h0000_00F0, 5'd4, 3'b010, 32'h0000_000F, 1'b0, 1'b0);
    drain(20);

    // Asynchronous reset with a stalled, full pipeline
    drive_cycle(1'b1, 32'hA5A5_A5A5, 5'd3, 3'b000, 1'b0, 1'b0, 32'hA5A5_A5A5, 1'b1, 1'b0, acc);
    for (int i = 0; i < 6; i++)
      drive_cycle(1'b1, 32'hFFFF_0000, 5'd0, 3'b111, 1'b0, 1'b0, 32'hFFFF_0000, 1'b0, 1'b0, acc);
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check_eq("pre_rst_err", {31'd0, out_op_err}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("async_rst_data", out_data, 32'd0);
    check_eq("async_rst_err", {31'd0, out_op_err}, 32'd0);
    q.delete();
    held = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", {31'd0, in_ready}, 32'd1);
    idle(10, 1'b1);
    check_eq("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the single-cycle 32-bit datapath shifter. Supports any power-of-two WIDTH.
- Ops: SLL, SRL, SRA, ROR, ROL, with the same 3-bit op encodings as the existing shifter.
- Valid/ready handshake with backpressure; one shift stage per amount bit, each followed by a register.
- Sits between the ALU operand mux and the writeback/forwarding path for wide or high-frequency configurations.

Parameters:
- WIDTH, 32, data width in bits; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width; also the pipeline depth. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous; drops all in-flight operations
- in_valid  input  1  input operation present
- in_ready  output  1  pipeline can accept this cycle
- in_data  input  WIDTH  operand
- in_amt  input  SHW  shift amount
- in_op  input  3  001 SLL, 010 SRL, 100 SRA, 110 ROR, 111 ROL
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result
- out_op_err  output  1  op code was not one of the five legal codes

Behaviour:
- Reset (rst_n low, async): all stage valid bits, out_valid, out_data, out_op_err and (if enabled) out_carry go to 0. in_ready goes to 1 once rst_n is high. Data registers may also be cleared.
- Pipeline structure:
  - SHW register stages.
  - Stage k applies a shift/rotate of 2^k when amt[k]=1 and carries op, remaining amt bits and sign bit forward.
  - Fill per op: SLL/SRL fill 0; SRA fills with the original in_data[WIDTH-1]; ROR/ROL wrap around.
- Latency and throughput: out_valid rises exactly SHW cycles after an accepted input when not stalled (WIDTH=32 gives 5 cycles). Throughput is one op per cycle.
- Handshake:
  - Transfer at the input when in_valid && in_ready; at the output when out_valid && out_ready.
  - Stage k advances when its successor is empty or advancing.
  - in_ready = !stage0_valid || stage0_advances; the combinational ready chain is permitted.
  - out_data, out_op_err and out_valid are held stable while out_valid && !out_ready.
  - No bubbles are inserted; no data is lost or duplicated under any stall pattern.
- Function (A = in_amt):
  - SLL = data << A
  - SRL = data >> A
  - SRA = signed data >>> A
  - ROR = (data >> A) | (data << (WIDTH-A))
  - ROL = (data << A) | (data >> (WIDTH-A))
- A=0: every op returns in_data unchanged.
- Illegal op (000, 011, 101): the result is in_data unchanged and out_op_err=1 with that result. The op still flows through the pipeline with normal handshake.
- flush=1 at a clock edge:
  - All stage valid bits and out_valid clear on that edge.
  - An input presented in the same cycle is dropped, even if in_ready=1.
  - flush has priority over advance.
- Reset mid-operation: all in-flight ops are discarded; nothing is emitted after reset deasserts until new inputs arrive.

Optional Feature:
- Macro: SHIFTER_CARRY_EN.
- With the macro defined, add output port out_carry (1 bit), pipelined alongside out_data, giving the last bit shifted out or wrapped:
  - SLL: in_data[WIDTH-A]
  - SRL: in_data[A-1]
  - SRA: in_data[A-1]
  - ROR: out_data[WIDTH-1]
  - ROL: out_data[0]
  - 0 when A=0 or on an illegal op.
- Without the macro: no out_carry port and no carry logic; all other behaviour is identical.

Test Plan:
- WIDTH=32, single ops with out_ready=1, in_data=32'h8000_00F1, A=4:
  - SLL -> 32'h0000_0F10
  - SRL -> 32'h0800_000F
  - SRA -> 32'hF800_000F
  - ROR -> 32'h1800_000F
  - ROL -> 32'h0000_0F18
  - Each result arrives exactly 5 cycles after acceptance.
- Back-to-back stream of 20 ops (random data/amt/op) with out_ready held 1 -> one result per cycle, in order, matching the reference model. Includes A=0 (identity) and A=31 (SRA of 32'h8000_0000 gives 32'hFFFF_FFFF).
- Backpressure: same stream with out_ready toggled pseudo-randomly and low for 8 consecutive cycles:
  - in_ready drops once all 5 stages are full.
  - out_data is stable while stalled.
  - No loss or duplication.
- Illegal op 3'b011 with in_data=32'h1234_5678 -> out_data=32'h1234_5678, out_op_err=1. The following legal op returns out_op_err=0.
- flush asserted with 3 ops in flight and a new in_valid in the same cycle -> out_valid=0 the next cycle and no stale results emerge. rst_n pulsed low mid-stream -> all outputs 0 immediately (asynchronously), and no outputs after release.
- With SHIFTER_CARRY_EN defined:
  - SRL in_data=32'h0000_0008, A=4 -> out_carry=1.
  - SLL in_data=32'h8000_0000, A=1 -> out_carry=1.
  - A=0 -> out_carry=0.
